kb_fifo: RTL and testbench
==========================

# kb_fifo

Parametrised keyboard receive buffer, successor to the fixed-size keyboard buffer. Captures bytes from the serial keyboard receiver on `rx_done`, stores them in a DEPTH-entry circular FIFO, and presents the oldest character to the Y86 memory-mapped I/O read path with a ready flag. Adds configurable width and depth, occupancy count, almost-full, selectable overflow policy, and sticky overflow/underflow error flags.

## Interface
- `DATA_W`, 7: stored character width; stores `rx_data[DATA_W-1:0]`; range 1..8.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AFULL_LVL`, DEPTH-2: `buf_almost_full` asserts when count ≥ this; range 1..DEPTH.
- `OVERWRITE`, 0: 0 = drop new byte when full; 1 = discard oldest byte and accept the new one.
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `KB_read_en  in  1`: pop request, one pop per cycle it is high.
- `KB_clear  in  1`: synchronous flush.
- `rx_data  in  8`: received byte, valid when `rx_done` high.
- `rx_done  in  1`: push strobe, one push per cycle it is high.
- `KB_status  out  1`: 1 = at least one character available (not empty).
- `KB_data  out  DATA_W`: head-of-FIFO character (show-ahead); 0 when empty.
- `buf_full  out  1`: count == DEPTH.
- `buf_almost_full  out  1`: count ≥ AFULL_LVL.
- `buf_count  out  $clog2(DEPTH+1)`: current occupancy.
- `buf_overflow  out  1`: sticky; set by any push attempted while full without a simultaneous pop.
- `buf_underflow  out  1`: sticky; set by `KB_read_en` while empty.

## Operation
- Storage: DEPTH × DATA_W register array; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register (0..DEPTH) drives full/empty.
- Push (`rx_done`=1): writes `rx_data[DATA_W-1:0]` at `wp`, `wp`+1, count+1.
- Pop (`KB_read_en`=1, count>0): `rp`+1, count−1. Pop while empty: no pointer change, `buf_underflow` set.
- Push + pop, 0<count<DEPTH: both execute; count unchanged.
- Push + pop, count==0: push executes, pop ignored, `buf_underflow` set; count→1.
- Push + pop, count==DEPTH: both execute; count stays DEPTH; no overflow.
- Push alone, count==DEPTH, OVERWRITE=0: byte dropped, state unchanged, `buf_overflow` set.
- Push alone, count==DEPTH, OVERWRITE=1: new byte written at `wp`, both `wp` and `rp` advance, count stays DEPTH, `buf_overflow` set; head becomes the former second-oldest entry.
- `KB_clear`=1: `wp`, `rp`, count → 0, `buf_overflow`, `buf_underflow` → 0; overrides any push/pop in the same cycle (those are discarded, flags not set). Memory contents not cleared.
- Error flags are cleared only by `KB_clear` or reset.
- `KB_data` = `mem[rp]` when count>0, else 0; combinational from registered state only (no path from inputs).

## Timing
- Reset (`rst_n`=0, asynchronous): `wp`=`rp`=count=0; `KB_status`=0, `KB_data`=0, `buf_full`=0, `buf_almost_full`=0 (AFULL_LVL≥1), `buf_count`=0, `buf_overflow`=0, `buf_underflow`=0. Reset mid-traffic discards all contents; release is synchronous to the next edge by the integrator.
- Push latency: `rx_done` sampled at edge N → `KB_status`, `KB_data`, `buf_count` updated immediately after edge N.
- Pop latency: `KB_read_en` at edge N → next character on `KB_data` (or `KB_status`=0) immediately after edge N. Consumer reads `KB_data` in the same cycle it asserts `KB_read_en`.
- Multi-cycle strobes: `rx_done` or `KB_read_en` held k cycles = k operations; upstream guarantees single-cycle `rx_done`.
- All flags derive from registered count; no combinational input-to-output paths.

## Test plan
- Reset then push "hello world" (68 65 6C 6C 6F 20 77 6F 72 6C 64), DEPTH=16: `buf_count`=11, `KB_status`=1, `KB_data`=7'h68, `buf_almost_full`=0; 11 pops return bytes in order, then `KB_status`=0, `KB_data`=0, no error flags.
- OVERWRITE=0, push 17 bytes 8'h01..8'h11: `buf_full`=1 after 16th, 17th dropped, `buf_overflow`=1, pops yield 01..10; `buf_almost_full` asserts at count 14.
- OVERWRITE=1, push 8'h01..8'h11: count=16, `buf_overflow`=1, `KB_data`=7'h02, last pop yields 7'h11.
- Simultaneous push+pop at count 0, 5, 16: counts become 1, 5, 16; `buf_underflow`=1 only for the empty case; no overflow at full; data order preserved.
- Push 8'hE5 (DATA_W=7): `KB_data`=7'h65; then `KB_clear` with `rx_done`=1 same cycle: count=0, `KB_status`=0, flags cleared, byte not stored.
- Pointer wrap: 40 interleaved push/pop pairs with incrementing data; every pop matches expected value across 2+ wraps; assert `rst_n`=0 mid-stream → all outputs zero asynchronously, before the next edge.

Source files
------------

// File: rtl/kb_fifo_if.sv
// Keyboard buffer bus: receiver push strobe, CPU pop/flush, and buffer status.
// The FIFO is the slave; the receiver/CPU side is the master.
interface kb_fifo_if #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              KB_read_en;
  logic              KB_clear;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              KB_status;
  logic [DATA_W-1:0] KB_data;
  logic              buf_full;
  logic              buf_almost_full;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_overflow;
  logic              buf_underflow;

  modport master (
    output KB_read_en, KB_clear, rx_data, rx_done,
    input  KB_status, KB_data, buf_full, buf_almost_full, buf_count,
           buf_overflow, buf_underflow
  );

  modport slave (
    input  KB_read_en, KB_clear, rx_data, rx_done,
    output KB_status, KB_data, buf_full, buf_almost_full, buf_count,
           buf_overflow, buf_underflow
  );
endinterface

// File: rtl/kb_fifo.sv
// Parametrised keyboard receive FIFO with show-ahead head, occupancy count,
// almost-full, selectable overflow policy and sticky error flags.
module kb_fifo #(
  parameter int DATA_W    = 7,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int OVERWRITE = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  kb_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
  localparam bit OW = (OVERWRITE != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              mem_we;
  logic              empty, full, do_pop, grow;
  logic              unused_rx_bits;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign unused_rx_bits = ^bus.rx_data;

  // NOTE: every signal gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    mem_we  = 1'b0;
    do_pop  = 1'b0;
    grow    = 1'b0;

    if (bus.KB_clear) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      do_pop = bus.KB_read_en && !empty;
      // A pop in the same cycle frees the slot, so a push at full is legal then.
      grow   = bus.rx_done && (!full || do_pop);

      if (bus.rx_done && (grow || OW)) begin
        mem_we = 1'b1;
        wp_d   = wp_q + PTR_W'(1);
      end

      if (bus.rx_done && full && !do_pop) begin
        ovf_d = 1'b1;
        // Overwrite mode evicts the oldest entry to make room.
        if (OW) rp_d = rp_q + PTR_W'(1);
      end

      if (do_pop) rp_d = rp_q + PTR_W'(1);
      if (bus.KB_read_en && empty) udf_d = 1'b1;

      count_d = count_q + CNT_W'(grow) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the zero count masks
  // stale contents and keeps the array as plain registers without reset muxes.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wp_q] <= bus.rx_data[DATA_W-1:0];
  end

  assign bus.KB_status       = !empty;
  assign bus.KB_data         = empty ? '0 : mem_q[rp_q];
  assign bus.buf_full        = full;
  assign bus.buf_almost_full = (count_q >= AFULL_C);
  assign bus.buf_count       = count_q;
  assign bus.buf_overflow    = ovf_q;
  assign bus.buf_underflow   = udf_q;
endmodule

// File: tb/tb_kb_fifo.sv
// Directed bench for kb_fifo: drop-new (dut0) and overwrite (dut1) variants
// driven with identical stimulus, checked against hand-computed values.
module tb_kb_fifo;
  localparam int DW    = 7;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kb_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) if0 ();
  kb_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) if1 ();

  kb_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(14), .OVERWRITE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  kb_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(14), .OVERWRITE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic rd, input logic clr, input logic done, input logic [7:0] d);
    if0.KB_read_en = rd; if0.KB_clear = clr; if0.rx_done = done; if0.rx_data = d;
    if1.KB_read_en = rd; if1.KB_clear = clr; if1.rx_done = done; if1.rx_data = d;
  endtask

  // Apply inputs for exactly one rising edge; return 1 time unit after it.
  task automatic drive(input logic rd, input logic clr, input logic done, input logic [7:0] d);
    set_inputs(rd, clr, done, d);
    @(posedge clk);
    #1;
    set_inputs(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic       rd, clr, done;
    logic [7:0] d;
    int         cnt;
    logic       st;
    logic [6:0] q;
    logic       full, af, ovf, udf;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] hw[11];

  initial begin
    //            rd clr done data   cnt st q      full af ovf udf
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h68, 1, 1'b1, 7'h68, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h65, 2, 1'b1, 7'h68, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h6C, 2, 1'b1, 7'h65, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b1, 7'h6C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h6C, 1, 1'b1, 7'h6C, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hE5, 1, 1'b1, 7'h65, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h33, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b1, 7'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    hw = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

    set_inputs(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst count",  32'(if0.buf_count), 0);
    check("rst status", 32'(if0.KB_status), 0);
    check("rst data",   32'(if0.KB_data), 0);
    check("rst full",   32'(if0.buf_full), 0);
    check("rst afull",  32'(if0.buf_almost_full), 0);
    check("rst ovf",    32'(if0.buf_overflow), 0);
    check("rst udf",    32'(if0.buf_underflow), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: basic push/pop, empty push+pop, DATA_W truncation, clear priority.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rd, vecs[i].clr, vecs[i].done, vecs[i].d);
      check($sformatf("vec%0d count", i),  32'(if0.buf_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d status", i), 32'(if0.KB_status), 32'(vecs[i].st));
      check($sformatf("vec%0d data", i),   32'(if0.KB_data), 32'(vecs[i].q));
      check($sformatf("vec%0d full", i),   32'(if0.buf_full), 32'(vecs[i].full));
      check($sformatf("vec%0d afull", i),  32'(if0.buf_almost_full), 32'(vecs[i].af));
      check($sformatf("vec%0d ovf", i),    32'(if0.buf_overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d udf", i),    32'(if0.buf_underflow), 32'(vecs[i].udf));
      check($sformatf("vec%0d ow data", i), 32'(if1.KB_data), 32'(vecs[i].q));
    end

    // "hello world"
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 1'b1, hw[i]);
    check("hw count",  32'(if0.buf_count), 11);
    check("hw status", 32'(if0.KB_status), 1);
    check("hw head",   32'(if0.KB_data), 32'h68);
    check("hw afull",  32'(if0.buf_almost_full), 0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("hw pop%0d", i), 32'(if0.KB_data), 32'(hw[i] & 8'h7F));
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("hw end status", 32'(if0.KB_status), 0);
    check("hw end data",   32'(if0.KB_data), 0);
    check("hw end ovf",    32'(if0.buf_overflow), 0);
    check("hw end udf",    32'(if0.buf_underflow), 0);

    // 17 pushes into 16 entries: drop-new vs overwrite-oldest.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(i));
      check($sformatf("ovf afull%0d", i), 32'(if0.buf_almost_full), (i >= 14) ? 1 : 0);
      check($sformatf("ovf full%0d", i),  32'(if0.buf_full), (i >= 16) ? 1 : 0);
    end
    check("drop count", 32'(if0.buf_count), 16);
    check("drop ovf",   32'(if0.buf_overflow), 1);
    check("drop head",  32'(if0.KB_data), 32'h01);
    check("ow count",   32'(if1.buf_count), 16);
    check("ow ovf",     32'(if1.buf_overflow), 1);
    check("ow head",    32'(if1.KB_data), 32'h02);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drop pop%0d", k), 32'(if0.KB_data), 32'(k + 1));
      check($sformatf("ow pop%0d", k),   32'(if1.KB_data), 32'(k + 2));
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("drain status", 32'(if0.KB_status), 0);
    check("drain udf",    32'(if0.buf_underflow), 0);

    // Simultaneous push+pop at count 5 and at full.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h20 + i));
    drive(1'b1, 1'b0, 1'b1, 8'h25);
    check("pp5 count", 32'(if0.buf_count), 5);
    check("pp5 head",  32'(if0.KB_data), 32'h21);
    check("pp5 udf",   32'(if0.buf_underflow), 0);
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h26 + i));
    check("ppF pre full", 32'(if0.buf_full), 1);
    drive(1'b1, 1'b0, 1'b1, 8'h50);
    check("ppF count",   32'(if0.buf_count), 16);
    check("ppF ovf",     32'(if0.buf_overflow), 0);
    check("ppF ow ovf",  32'(if1.buf_overflow), 0);
    check("ppF head",    32'(if0.KB_data), 32'h22);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("ppF pop%0d", k), 32'(if0.KB_data), 32'(8'h22 + k));
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("ppF last", 32'(if0.KB_data), 32'h50);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("ppF empty", 32'(if0.buf_count), 0);

    // Pointer wrap: steady one-deep streaming over 40 push+pop pairs.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 40; i++) begin
      check($sformatf("wrap pop%0d", i), 32'(if0.KB_data), 32'(i - 1));
      drive(1'b1, 1'b0, 1'b1, 8'(i));
    end
    check("wrap count", 32'(if0.buf_count), 1);
    check("wrap head",  32'(if0.KB_data), 32'h28);
    drive(1'b0, 1'b0, 1'b1, 8'h29);
    drive(1'b0, 1'b0, 1'b1, 8'h2A);
    check("pre-rst count", 32'(if0.buf_count), 3);

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst count",  32'(if0.buf_count), 0);
    check("arst status", 32'(if0.KB_status), 0);
    check("arst data",   32'(if0.KB_data), 0);
    check("arst full",   32'(if0.buf_full), 0);
    check("arst afull",  32'(if0.buf_almost_full), 0);
    check("arst ovf",    32'(if0.buf_overflow), 0);
    check("arst udf",    32'(if0.buf_underflow), 0);
    check("arst ow cnt", 32'(if1.buf_count), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst count", 32'(if0.buf_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
